// File: rtl/ring_monitor.sv
// Supervisor for a one-hot ring counter. It tracks the active phase, counts revolutions,
// and re-seeds the ring through load_req when the ring stalls or is corrupted.
module ring_monitor #(
  parameter  int WIDTH     = 4,
  parameter  int REV_W     = 8,
  parameter  int ERR_LIMIT = 3,
  localparam int PH_W      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] ring,
  input  logic             err_clr,
  output logic [PH_W-1:0]  phase,
  output logic             phase_valid,
  output logic             rev_tick,
  output logic [REV_W-1:0] rev_count,
  output logic             load_req,
  output logic             err
);

  localparam int               BC_W  = $clog2(ERR_LIMIT + 1);
  localparam logic [BC_W-1:0]  LIMIT = BC_W'(ERR_LIMIT);
  localparam logic [WIDTH-1:0] SEED  = WIDTH'(1);

  localparam logic [1:0] SYNC    = 2'd0;
  localparam logic [1:0] TRACK   = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;
  localparam logic [1:0] WAIT    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] s_prev;
  logic [BC_W-1:0]  bad_cnt, bad_d;
  logic [PH_W-1:0]  phase_d, s_idx;
  logic             legal, next_ok, err_set, tick_d;

  assign legal   = (ring != '0) && ((ring & (ring - SEED)) == '0);
  assign next_ok = (ring == {s_prev[WIDTH-2:0], s_prev[WIDTH-1]});

  // Bit index of the set bit; only meaningful when the sample is legal.
  always_comb begin
    s_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring[i]) s_idx = s_idx | PH_W'(i);
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    phase_d = phase;
    bad_d   = bad_cnt;
    err_set = 1'b0;
    tick_d  = 1'b0;
    case (state_q)
      SYNC: begin
        if (legal) begin
          state_d = TRACK;
          phase_d = s_idx;
          bad_d   = '0;
        end else begin
          if (bad_cnt != LIMIT) bad_d = bad_cnt + BC_W'(1);
          if (bad_d == LIMIT) begin
            state_d = RECOVER;
            err_set = 1'b1;
          end
        end
      end
      TRACK: begin
        if (legal && next_ok) begin
          phase_d = s_idx;
          bad_d   = '0;
          tick_d  = ring[0];
        end else begin
          bad_d   = BC_W'(1);
          err_set = 1'b1;
          state_d = (ERR_LIMIT == 1) ? RECOVER : SYNC;
        end
      end
      RECOVER: state_d = WAIT;
      WAIT: begin
        if (ring == SEED) begin
          state_d = TRACK;
          phase_d = '0;
          bad_d   = '0;
        end else begin
          state_d = RECOVER;
          err_set = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= SYNC;
      s_prev      <= '0;
      bad_cnt     <= '0;
      phase       <= '0;
      phase_valid <= 1'b0;
      rev_tick    <= 1'b0;
      rev_count   <= '0;
      load_req    <= 1'b0;
      err         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop sees pre-edge values.
      state_q     <= state_d;
      s_prev      <= ring;
      bad_cnt     <= bad_d;
      phase       <= phase_d;
      phase_valid <= (state_d == TRACK);
      rev_tick    <= tick_d;
      if (tick_d) rev_count <= rev_count + REV_W'(1);
      load_req    <= (state_d == RECOVER);
      err         <= err_set | (err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_ring_monitor.sv
// Self-checking bench for ring_monitor: a behavioural reference model checked every cycle,
// plus directed scenarios with hand-computed expectations and a randomized soak.
module tb_ring_monitor;
  localparam int W   = 4;
  localparam int RW  = 8;
  localparam int LIM = 3;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic [W-1:0]  ring = '0;
  logic          err_clr = 1'b0;
  logic [1:0]    phase;
  logic          phase_valid, rev_tick, load_req, err;
  logic [RW-1:0] rev_count;

  ring_monitor #(.WIDTH(W), .REV_W(RW), .ERR_LIMIT(LIM)) dut (
    .clk(clk), .clr_n(clr_n), .ring(ring), .err_clr(err_clr),
    .phase(phase), .phase_valid(phase_valid), .rev_tick(rev_tick),
    .rev_count(rev_count), .load_req(load_req), .err(err)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  // Stimulus source: a bench ring counter (rm) or a forced value, optionally corrupted.
  bit         use_ring = 1'b0;
  bit         rand_mode = 1'b0;
  bit         load_prev = 1'b0;
  logic [W-1:0] force_val = '0;
  logic [W-1:0] rm = '0;

  initial forever begin
    @(negedge clk);
    if (!clr_n) load_prev = 1'b0;
    else begin
      rm = load_prev ? W'(1) : {rm[W-2:0], rm[W-1]};
      load_prev = load_req;
      if (rand_mode && ($urandom_range(0, 199) == 0)) rm = '0;
    end
    if (rand_mode && ($urandom_range(0, 9) == 0)) ring = W'($urandom);
    else ring = use_ring ? rm : force_val;
    if (rand_mode) err_clr = ($urandom_range(0, 7) == 0);
  end

  // Reference model, stepped once per sample using integer arithmetic.
  typedef enum {M_SYNC, M_TRACK, M_RECOVER, M_WAIT} mode_t;
  mode_t m_mode = M_SYNC;
  int    m_bad = 0, m_phase = 0, m_prev = 0, m_rev = 0;
  bit    m_err = 1'b0, m_tick = 1'b0;

  initial forever begin
    @(posedge clk or negedge clr_n);
    if (!clr_n) begin
      m_mode = M_SYNC; m_bad = 0; m_phase = 0; m_prev = 0; m_rev = 0;
      m_err = 1'b0; m_tick = 1'b0;
    end else begin
      int  s;
      bit  is_legal, in_seq, set_err;
      s        = int'(ring);
      is_legal = ($countones(ring) == 1);
      in_seq   = (s == (((m_prev * 2) % (1 << W)) + (m_prev / (1 << (W - 1)))));
      set_err  = 1'b0;
      m_tick   = 1'b0;
      case (m_mode)
        M_SYNC:
          if (is_legal) begin
            m_mode = M_TRACK; m_phase = $clog2(s); m_bad = 0;
          end else begin
            m_bad = (m_bad + 1 > LIM) ? LIM : m_bad + 1;
            if (m_bad == LIM) begin m_mode = M_RECOVER; set_err = 1'b1; end
          end
        M_TRACK:
          if (is_legal && in_seq) begin
            m_phase = $clog2(s); m_bad = 0;
            if (m_phase == 0) begin m_tick = 1'b1; m_rev = (m_rev + 1) % (1 << RW); end
          end else begin
            m_bad = 1; set_err = 1'b1;
            m_mode = (LIM == 1) ? M_RECOVER : M_SYNC;
          end
        M_RECOVER: m_mode = M_WAIT;
        M_WAIT:
          if (s == 1) begin
            m_mode = M_TRACK; m_phase = 0; m_bad = 0;
          end else begin
            m_mode = M_RECOVER; set_err = 1'b1;
          end
        default: m_mode = M_SYNC;
      endcase
      if (set_err) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      m_prev = s;
    end
  end

  // Compare process: every cycle, midway between active edges.
  initial forever begin
    @(negedge clk);
    check("cmp_phase_valid", 32'(phase_valid), 32'(m_mode == M_TRACK));
    check("cmp_phase",       32'(phase),       32'(m_phase));
    check("cmp_rev_tick",    32'(rev_tick),    32'(m_tick));
    check("cmp_rev_count",   32'(rev_count),   32'(m_rev));
    check("cmp_load_req",    32'(load_req),    32'(m_mode == M_RECOVER));
    check("cmp_err",         32'(err),         32'(m_err));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  loads, ticks, last_tick;
    bit  found, saw_wrap;

    // Reset state.
    step(); step();
    check("rst_phase_valid", 32'(phase_valid), 0);
    check("rst_load_req",    32'(load_req),    0);
    check("rst_err",         32'(err),         0);
    check("rst_rev_count",   32'(rev_count),   0);

    // Ring held at 0000 with nothing attached: retries every 2 cycles from edge 3.
    use_ring = 1'b0; force_val = '0;
    clr_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      check("stall_load_req",    32'(load_req),    32'((k >= 3) && (k % 2 == 1)));
      check("stall_err",         32'(err),         32'(k >= 3));
      check("stall_phase_valid", 32'(phase_valid), 0);
    end

    // Real ring, cleared: one re-seed, then 10 clean revolutions.
    clr_n = 1'b0; step(); step();
    rm = '0; use_ring = 1'b1;
    clr_n = 1'b1;
    loads = 0; ticks = 0; last_tick = 0;
    for (int k = 1; k <= 45; k++) begin
      step();
      if (load_req) loads++;
      if (k >= 5 && k <= 8) begin
        check("ring_phase_valid", 32'(phase_valid), 1);
        check("ring_phase",       32'(phase),       32'((k - 5) % 4));
      end
      if (rev_tick) begin
        ticks++;
        if (last_tick == 0) check("first_tick_edge", 32'(k), 9);
        else check("tick_spacing", 32'(k - last_tick), 4);
        last_tick = k;
      end
    end
    check("ring_load_pulses", 32'(loads), 1);
    check("ring_ticks",       32'(ticks), 10);
    check("ring_rev_count",   32'(rev_count), 10);

    // Forced skip 0001 -> 0100, then resync on 1000 without recovery.
    use_ring = 1'b0; force_val = 4'b0100;
    step();
    check("skip_phase_valid", 32'(phase_valid), 0);
    check("skip_err",         32'(err),         1);
    check("skip_phase_held",  32'(phase),       0);
    force_val = 4'b1000;
    step();
    check("resync_phase_valid", 32'(phase_valid), 1);
    check("resync_phase",       32'(phase),       3);
    check("resync_load_req",    32'(load_req),    0);
    rm = 4'b1000; use_ring = 1'b1; err_clr = 1'b1;
    step();
    check("errclr_err",       32'(err),       0);
    check("errclr_rev_tick",  32'(rev_tick),  1);
    check("errclr_rev_count", 32'(rev_count), 11);
    err_clr = 1'b0;
    step();

    // err_clr coinciding with a TRACK fault: set wins.
    use_ring = 1'b0; force_val = '0; err_clr = 1'b1;
    step();
    check("setwins_err",         32'(err),         1);
    check("setwins_phase_valid", 32'(phase_valid), 0);
    check("setwins_phase_held",  32'(phase),       1);
    err_clr = 1'b0; rm = '0; use_ring = 1'b1;
    for (int k = 0; k < 10; k++) step();
    check("reseed_phase_valid", 32'(phase_valid), 1);
    check("reseed_phase",       32'(phase),       2);
    check("reseed_rev_count",   32'(rev_count),   12);

    // 256 clean revolutions: counter wraps back to its start value.
    ticks = 0; saw_wrap = 1'b0;
    for (int k = 0; k < 1024; k++) begin
      step();
      if (rev_tick) begin
        ticks++;
        if (rev_count == '0) saw_wrap = 1'b1;
      end
    end
    check("wrap_ticks",     32'(ticks),     256);
    check("wrap_rev_count", 32'(rev_count), 12);
    check("wrap_seen",      32'(saw_wrap),  1);

    // Asynchronous reset while load_req is high.
    use_ring = 1'b0; force_val = '0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (load_req) found = 1'b1;
    end
    check("async_load_seen", 32'(found), 1);
    clr_n = 1'b0;
    #1;
    check("async_load_req",    32'(load_req),    0);
    check("async_phase_valid", 32'(phase_valid), 0);
    check("async_phase",       32'(phase),       0);
    check("async_rev_count",   32'(rev_count),   0);
    check("async_rev_tick",    32'(rev_tick),    0);
    check("async_err",         32'(err),         0);
    step(); step();
    clr_n = 1'b1;
    step();
    check("post_async_phase_valid", 32'(phase_valid), 0);

    // Randomized soak against the model.
    rm = W'(1); use_ring = 1'b1; rand_mode = 1'b1;
    for (int k = 0; k < 3000; k++) step();
    rand_mode = 1'b0;
    err_clr = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
